// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generator for the EX-stage ALU.
// Shadows the destination/write/load flags of the instructions in EX and MEM.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  ext_stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_dst;
    logic                  ex_wr;
    logic                  ex_ld;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic                  mem_wr;

    logic ex_prod;
    logic mem_prod;
    logic a_ex_hit;
    logic b_ex_hit;
    logic a_mem_hit;
    logic b_mem_hit;
    logic load_ex;
    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;

    // A slot can only supply a forward if it will actually write a nonzero register.
    assign ex_prod  = ex_valid & ex_wr & (ex_dst != '0);
    assign mem_prod = mem_valid & mem_wr & (mem_dst != '0);

    assign a_ex_hit  = ex_prod  & id_use_rs & (id_rs == ex_dst);
    assign b_ex_hit  = ex_prod  & id_use_rt & (id_rt == ex_dst);
    assign a_mem_hit = mem_prod & id_use_rs & (id_rs == mem_dst);
    assign b_mem_hit = mem_prod & id_use_rt & (id_rt == mem_dst);

    assign stall = id_valid & ex_valid & ex_ld & (ex_dst != '0) &
                   ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));

    assign load_ex = id_valid & ~stall & ~flush;

    always_comb begin
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
        if (load_ex) begin
            if (a_ex_hit)
                sel_a_nxt = SEL_EX;
            else if (a_mem_hit)
                sel_a_nxt = SEL_MEM;
            if (b_ex_hit)
                sel_b_nxt = SEL_EX;
            else if (b_mem_hit)
                sel_b_nxt = SEL_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_dst      <= '0;
            ex_wr       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_valid   <= 1'b0;
            mem_dst     <= '0;
            mem_wr      <= 1'b0;
            fwd_a_sel   <= SEL_RF;
            fwd_b_sel   <= SEL_RF;
            stall_count <= '0;
        end else if (!ext_stall) begin
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            mem_wr    <= ex_wr;
            if (load_ex) begin
                ex_valid <= 1'b1;
                ex_dst   <= id_dst;
                ex_wr    <= id_reg_write;
                ex_ld    <= id_mem_read;
            end else begin
                ex_valid <= 1'b0;
                ex_dst   <= '0;
                ex_wr    <= 1'b0;
                ex_ld    <= 1'b0;
            end
            fwd_a_sel <= sel_a_nxt;
            fwd_b_sel <= sel_b_nxt;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: expected selects are queued when an
// ID instruction is driven and compared after the edge that registers them.
module tb_fwd_hazard_unit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         id_valid = 1'b0;
    logic [W-1:0] id_rs = '0;
    logic [W-1:0] id_rt = '0;
    logic         id_use_rs = 1'b0;
    logic         id_use_rt = 1'b0;
    logic [W-1:0] id_dst = '0;
    logic         id_reg_write = 1'b0;
    logic         id_mem_read = 1'b0;
    logic         flush = 1'b0;
    logic         ext_stall = 1'b0;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;
    logic [15:0] stall_count;
    logic [1:0]  sat_a_sel, sat_b_sel;
    logic        sat_stall;
    logic [1:0]  sat_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;
    logic [3:0] exp_q[$];

    fwd_hazard_unit #(.REG_ADDR_W(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ext_stall(ext_stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_ADDR_W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ext_stall(ext_stall), .fwd_a_sel(sat_a_sel), .fwd_b_sel(sat_b_sel),
        .stall(sat_stall), .stall_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         input logic urs, input logic urt, input logic [W-1:0] dst,
                         input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst; id_reg_write = wr; id_mem_read = ld;
    endtask

    // Check the combinational stall, queue the selects expected after the edge,
    // clock once, then pop and compare.
    task automatic cyc(input logic [1:0] ea, input logic [1:0] eb, input logic es,
                       input string name);
        logic [3:0] e;
        #1;
        n_tests++;
        if (stall !== es) begin
            n_fail++;
            $display("FAIL %s stall: got %b want %b", name, stall, es);
        end
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s sel: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if ({fwd_a_sel, fwd_b_sel} !== e) begin
                n_fail++;
                $display("FAIL %s sel: got a=%b b=%b want a=%b b=%b",
                         name, fwd_a_sel, fwd_b_sel, e[3:2], e[1:0]);
            end
        end
    endtask

    task automatic check_count(input string name);
        int sat_exp;
        sat_exp = (exp_count > 3) ? 3 : exp_count;
        n_tests++;
        if (stall_count !== 16'(exp_count) || sat_count !== 2'(sat_exp)) begin
            n_fail++;
            $display("FAIL %s count: got %0d/%0d want %0d/%0d",
                     name, stall_count, sat_count, exp_count, sat_exp);
        end
    endtask

    task automatic nops();
        flush = 1'b0; ext_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(2'b00, 2'b00, 1'b0, "nop0");
        cyc(2'b00, 2'b00, 1'b0, "nop1");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, W'($urandom), W'($urandom), 1, 1, W'($urandom), 1, 1'($urandom));
            flush = 1'($urandom); ext_stall = 1'($urandom);
            #1;
            n_tests++;
            if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0 ||
                stall_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got a=%b b=%b stall=%b cnt=%0d want 0",
                         fwd_a_sel, fwd_b_sel, stall, stall_count);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;
        exp_count = 0;
        drive(1, 0, 0, 0, 0, 3, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "rst_add3");
        drive(1, 3, 0, 1, 0, 7, 1, 1);
        cyc(2'b01, 2'b00, 1'b0, "rst_lw7");
        drive(1, 7, 0, 1, 0, 9, 1, 0);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_stall: got %b want 1", stall);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0 ||
            stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_async: got a=%b b=%b stall=%b cnt=%0d want 0",
                     fwd_a_sel, fwd_b_sel, stall, stall_count);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        nops();
    endtask

    task automatic test_ex_forward();
        nops();
        drive(1, 0, 0, 0, 0, 3, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "exf_add3");
        drive(1, 3, 4, 1, 1, 9, 1, 0);
        cyc(2'b01, 2'b00, 1'b0, "exf_sub");
    endtask

    task automatic test_mem_forward();
        nops();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "memf_add5");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(2'b00, 2'b00, 1'b0, "memf_nop");
        drive(1, 5, 2, 1, 1, 11, 1, 0);
        cyc(2'b10, 2'b00, 1'b0, "memf_use");
        nops();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "prio_add5a");
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "prio_add5b");
        drive(1, 5, 5, 1, 1, 12, 1, 0);
        cyc(2'b01, 2'b01, 1'b0, "prio_use");
        // B from MEM while A comes from EX
        nops();
        drive(1, 0, 0, 0, 0, 6, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "mix_add6");
        drive(1, 0, 0, 0, 0, 4, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "mix_add4");
        drive(1, 4, 6, 1, 1, 13, 1, 0);
        cyc(2'b01, 2'b10, 1'b0, "mix_use");
    endtask

    task automatic test_load_use();
        nops();
        drive(1, 0, 0, 0, 0, 7, 1, 1);
        cyc(2'b00, 2'b00, 1'b0, "lu_lw7");
        drive(1, 7, 2, 1, 1, 10, 1, 0);
        cyc(2'b00, 2'b00, 1'b1, "lu_stall");
        exp_count++;
        check_count("lu_cnt1");
        cyc(2'b10, 2'b00, 1'b0, "lu_retry");
        check_count("lu_cnt2");
    endtask

    task automatic test_zero_unused();
        nops();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "z_add0");
        drive(1, 0, 0, 1, 1, 14, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "z_use0");
        nops();
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        cyc(2'b00, 2'b00, 1'b0, "z_lw0");
        drive(1, 0, 0, 1, 1, 14, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "z_nostall0");
        nops();
        drive(1, 0, 0, 0, 0, 8, 1, 1);
        cyc(2'b00, 2'b00, 1'b0, "u_lw8");
        drive(1, 1, 8, 1, 0, 15, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "u_rt_unused");
        check_count("u_cnt");
    endtask

    task automatic test_ext_stall();
        nops();
        drive(1, 0, 0, 0, 0, 6, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "es_add6");
        drive(1, 6, 0, 1, 0, 7, 1, 1);
        cyc(2'b01, 2'b00, 1'b0, "es_lw7");
        drive(1, 7, 0, 1, 0, 9, 1, 0);
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 2'b00, 1'b1, "es_frozen");
            check_count("es_cnt_frozen");
        end
        ext_stall = 1'b0;
        cyc(2'b00, 2'b00, 1'b1, "es_release");
        exp_count++;
        check_count("es_cnt");
        cyc(2'b10, 2'b00, 1'b0, "es_retry");
    endtask

    task automatic test_flush();
        nops();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        cyc(2'b00, 2'b00, 1'b0, "fl_add5");
        drive(1, 5, 5, 1, 1, 9, 1, 0);
        flush = 1'b1;
        cyc(2'b00, 2'b00, 1'b0, "fl_killed");
        flush = 1'b0;
        drive(1, 5, 9, 1, 1, 10, 1, 0);
        cyc(2'b10, 2'b00, 1'b0, "fl_next");
        nops();
        drive(1, 0, 0, 0, 0, 7, 1, 1);
        cyc(2'b00, 2'b00, 1'b0, "fls_lw7");
        drive(1, 0, 7, 0, 1, 9, 1, 0);
        flush = 1'b1;
        cyc(2'b00, 2'b00, 1'b1, "fls_both");
        flush = 1'b0;
        exp_count++;
        check_count("fls_cnt");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            nops();
            drive(1, 0, 0, 0, 0, 7, 1, 1);
            cyc(2'b00, 2'b00, 1'b0, "sat_lw7");
            drive(1, 7, 0, 1, 0, 9, 1, 0);
            cyc(2'b00, 2'b00, 1'b1, "sat_stall");
            exp_count++;
            check_count("sat_cnt");
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_zero_unused();
        test_ext_stall();
        test_flush();
        test_saturation();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
